// File: rtl/bus_pkg.sv
// bus_pkg: FSM state encoding and parameter defaults for mem_bus_arb
package bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, DATA, DONE} state_t;
  localparam int NCH_DEF = 2;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 20;
  localparam int WAIT_CYC_DEF = 1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of the first unmasked request found searching upward from ptr_i
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic [N-1:0] elig;
  logic found;
  assign elig = req_i & ~mask_i;
  // walk offsets from the pointer; the first eligible channel wins
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!found && elig[j] && ((int'(ptr_i) + i) % N) == j) begin
          gnt_o[j] = 1'b1;
          found = 1'b1;
        end
  end
endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: NCH-channel arbiter onto a multiplexed address/data memory bus
// ARB_RR_EN defined: round-robin grant; undefined: fixed priority, lowest index wins
module mem_bus_arb import bus_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    rw,
  input  logic [NCH*AW-1:0] adr,
  input  logic [NCH*DW-1:0] dtw,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     dtr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  output logic              isout,
  output logic [AW-DW-1:0]  adr_hi,
  output logic              ale,
  output logic              oe,
  output logic              we,
  output logic              busy
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  state_t state_q, state_d;
  logic [NCH-1:0] gnt, gnt_q, gnt_d, mask_q, mask_d;
  logic rw_q, rw_d, sel_rw;
  logic [AW-1:0] adr_q, adr_d, sel_adr;
  logic [DW-1:0] dtw_q, dtw_d, sel_dtw, dtr_q, dtr_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [PW-1:0] ptr;
  logic start, last;
  assign start = (state_q == IDLE) && |gnt;
  assign last = (state_q == DATA) && (wcnt_q == 4'(WAIT_CYC));
  assign dtr = dtr_q;
  rr_arbiter #(.N(NCH), .PW(PW)) u_arb (
    .req_i (req),
    .mask_i(mask_q),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );
`ifdef ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
  // pointer moves to the channel after the one just granted
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NCH; i++)
      if (start && gnt[i]) ptr_d = PW'((i + 1) % NCH);
  end
  // round-robin pointer register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  assign ptr = '0;
`endif
  // request fields of the channel currently being granted
  always_comb begin
    sel_rw = 1'b0;
    sel_adr = '0;
    sel_dtw = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) begin
        sel_rw = rw[i];
        sel_adr = adr[i*AW +: AW];
        sel_dtw = dtw[i*DW +: DW];
      end
  end
  // bus phase sequencing, request capture at grant, read data capture
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ADDR : IDLE;
      ADDR:    state_d = LATCH;
      LATCH:   state_d = DATA;
      DATA:    state_d = last ? DONE : DATA;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = start ? gnt : gnt_q;
    rw_d = start ? sel_rw : rw_q;
    adr_d = start ? sel_adr : adr_q;
    dtw_d = start ? sel_dtw : dtw_q;
    mask_d = (state_q == DONE) ? gnt_q : '0;
    wcnt_d = (state_q == DATA) ? wcnt_q + 4'd1 : 4'd0;
    dtr_d = (last && rw_q) ? din : dtr_q;
  end
  // state and captured-request registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rw_q <= 1'b0;
      adr_q <= '0;
      dtw_q <= '0;
      mask_q <= '0;
      wcnt_q <= '0;
      dtr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rw_q <= rw_d;
      adr_q <= adr_d;
      dtw_q <= dtw_d;
      mask_q <= mask_d;
      wcnt_q <= wcnt_d;
      dtr_q <= dtr_d;
    end
  // bus strobes and pin values decoded from the current phase
  always_comb begin
    ack = '0;
    dout = '0;
    isout = 1'b0;
    ale = 1'b0;
    oe = 1'b0;
    we = 1'b0;
    busy = state_q != IDLE;
    adr_hi = (state_q == IDLE) ? '0 : adr_q[AW-1:DW];
    case (state_q)
      ADDR: begin
        isout = 1'b1;
        dout = adr_q[DW-1:0];
        ale = 1'b1;
      end
      LATCH: begin
        isout = 1'b1;
        dout = adr_q[DW-1:0];
      end
      DATA: begin
        oe = rw_q;
        we = !rw_q;
        isout = !rw_q;
        dout = rw_q ? '0 : dtw_q;
      end
      DONE: begin
        ack = gnt_q;
        isout = !rw_q;
        dout = rw_q ? '0 : dtw_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed self-checking bench for mem_bus_arb (default and 4-channel builds)
module tb_mem_bus_arb;
  logic clk, rst_n;
  logic [1:0] req0, rw0, ack0;
  logic [39:0] adr0;
  logic [31:0] dtw0;
  logic [15:0] dtr0, din0, dout0;
  logic [3:0] adr_hi0;
  logic isout0, ale0, oe0, we0, busy0;
  logic [3:0] req1, rw1, ack1, adr_hi1;
  logic [47:0] adr1;
  logic [31:0] dtw1;
  logic [7:0] dtr1, din1, dout1;
  logic isout1, ale1, oe1, we1, busy1;
  int checks = 0;
  int failures = 0;
  logic [1:0] a0;
  logic [3:0] a1;
  logic [3:0] exp1 [4];
  mem_bus_arb u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .rw(rw0), .adr(adr0), .dtw(dtw0),
    .ack(ack0), .dtr(dtr0), .din(din0), .dout(dout0), .isout(isout0),
    .adr_hi(adr_hi0), .ale(ale0), .oe(oe0), .we(we0), .busy(busy0)
  );
  mem_bus_arb #(.NCH(4), .DW(8), .AW(12), .WAIT_CYC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .rw(rw1), .adr(adr1), .dtw(dtw1),
    .ack(ack1), .dtr(dtr1), .din(din1), .dout(dout1), .isout(isout1),
    .adr_hi(adr_hi1), .ale(ale1), .oe(oe1), .we(we1), .busy(busy1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack0(output logic [1:0] a);
    a = '0;
    for (int n = 0; n < 20 && a == 2'b00; n++) begin
      @(negedge clk);
      a = ack0;
    end
  endtask
  task automatic wait_ack1(output logic [3:0] a);
    a = '0;
    for (int n = 0; n < 20 && a == 4'b0000; n++) begin
      @(negedge clk);
      a = ack1;
    end
  endtask
  initial begin
`ifdef ARB_RR_EN
    exp1[0] = 4'b1000; exp1[1] = 4'b0001; exp1[2] = 4'b0010; exp1[3] = 4'b0100;
`else
    exp1[0] = 4'b0001; exp1[1] = 4'b0010; exp1[2] = 4'b0001; exp1[3] = 4'b0010;
`endif
    rst_n = 1'b0;
    req0 = '0; rw0 = '0; adr0 = '0; dtw0 = '0; din0 = '0;
    req1 = '0; rw1 = '0; adr1 = '0; dtw1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0); chk("rst_ack", ack0, 0); chk("rst_dtr", dtr0, 0);
    chk("rst_dout", dout0, 0); chk("rst_isout", isout0, 0); chk("rst_adr_hi", adr_hi0, 0);
    chk("rst_ale", ale0, 0); chk("rst_oe", oe0, 0); chk("rst_we", we0, 0); chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    // single read on channel 0
    @(negedge clk);
    req0 = 2'b01; rw0 = 2'b01; adr0[19:0] = 20'hA1234; din0 = 16'hBEEF;
    @(negedge clk);
    chk("rd_addr_ale", ale0, 1); chk("rd_addr_dout", dout0, 16'h1234); chk("rd_addr_isout", isout0, 1);
    chk("rd_adr_hi", adr_hi0, 4'hA); chk("rd_busy", busy0, 1); chk("rd_addr_ack", ack0, 0);
    @(negedge clk);
    chk("rd_latch_ale", ale0, 0); chk("rd_latch_dout", dout0, 16'h1234); chk("rd_latch_oe", oe0, 0);
    @(negedge clk);
    chk("rd_data1_oe", oe0, 1); chk("rd_data1_isout", isout0, 0); chk("rd_data1_we", we0, 0); chk("rd_data1_ack", ack0, 0);
    @(negedge clk);
    chk("rd_data2_oe", oe0, 1); chk("rd_data2_ack", ack0, 0);
    @(negedge clk);
    chk("rd_done_ack", ack0, 2'b01); chk("rd_done_oe", oe0, 0); chk("rd_dtr", dtr0, 16'hBEEF); chk("rd_done_adr_hi", adr_hi0, 4'hA);
    req0 = 2'b00;
    @(negedge clk);
    chk("rd_idle_ack", ack0, 0); chk("rd_idle_busy", busy0, 0); chk("rd_idle_adr_hi", adr_hi0, 0);
    // single write on channel 1
    req0 = 2'b10; rw0 = 2'b00; adr0[39:20] = 20'h00010; dtw0[31:16] = 16'h5A5A; din0 = 16'h1111;
    @(negedge clk);
    chk("wr_addr_dout", dout0, 16'h0010); chk("wr_addr_ale", ale0, 1); chk("wr_adr_hi", adr_hi0, 0);
    @(negedge clk);
    chk("wr_latch_dout", dout0, 16'h0010);
    @(negedge clk);
    chk("wr_data1_we", we0, 1); chk("wr_data1_oe", oe0, 0); chk("wr_data1_isout", isout0, 1); chk("wr_data1_dout", dout0, 16'h5A5A);
    @(negedge clk);
    chk("wr_data2_we", we0, 1); chk("wr_data2_dout", dout0, 16'h5A5A);
    @(negedge clk);
    chk("wr_done_we", we0, 0); chk("wr_done_isout", isout0, 1); chk("wr_done_dout", dout0, 16'h5A5A);
    chk("wr_done_ack", ack0, 2'b10); chk("wr_dtr_kept", dtr0, 16'hBEEF);
    req0 = 2'b00;
    @(negedge clk);
    chk("wr_idle_ack", ack0, 0); chk("wr_idle_isout", isout0, 0); chk("wr_idle_dtr", dtr0, 16'hBEEF);
    // two channels requesting continuously alternate in either arbitration mode
    req0 = 2'b11; rw0 = 2'b11; din0 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      wait_ack0(a0);
      chk($sformatf("alt2_%0d", k), a0, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req0 = 2'b00;
    // asynchronous reset in the data phase of a write
    @(negedge clk);
    req0 = 2'b01; rw0 = 2'b00; adr0[19:0] = 20'h12345; dtw0[15:0] = 16'h7777;
    repeat (3) @(negedge clk);
    chk("ar_pre_we", we0, 1); chk("ar_pre_busy", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", we0, 0); chk("ar_isout", isout0, 0); chk("ar_busy", busy0, 0);
    chk("ar_ack", ack0, 0); chk("ar_dtr", dtr0, 0); chk("ar_adr_hi", adr_hi0, 0);
    req0 = 2'b00;
    @(negedge clk);
    chk("ar_hold_busy", busy0, 0); chk("ar_hold_ack", ack0, 0);
    rst_n = 1'b1;
    req0 = 2'b01; rw0 = 2'b01; adr0[19:0] = 20'h50042; din0 = 16'h0F0F;
    @(negedge clk);
    chk("ar_re_ale", ale0, 1); chk("ar_re_dout", dout0, 16'h0042); chk("ar_re_adr_hi", adr_hi0, 4'h5);
    wait_ack0(a0);
    chk("ar_re_ack", a0, 2'b01);
    req0 = 2'b00;
    chk("ar_re_dtr", dtr0, 16'h0F0F);
    // 4-channel, 8-bit, zero-wait read on channel 2
    @(negedge clk);
    req1 = 4'b0100; rw1 = 4'b0100; adr1[35:24] = 12'h3C7; din1 = 8'h9D;
    @(negedge clk);
    chk("n4_addr_dout", dout1, 8'hC7); chk("n4_adr_hi", adr_hi1, 4'h3); chk("n4_ale", ale1, 1); chk("n4_isout", isout1, 1);
    @(negedge clk);
    chk("n4_latch_ack", ack1, 0); chk("n4_latch_ale", ale1, 0);
    @(negedge clk);
    chk("n4_data_oe", oe1, 1); chk("n4_data_ack", ack1, 0);
    @(negedge clk);
    chk("n4_done_ack", ack1, 4'b0100); chk("n4_dtr", dtr1, 8'h9D); chk("n4_done_oe", oe1, 0);
    req1 = 4'b0000;
    @(negedge clk);
    chk("n4_idle_ack", ack1, 0); chk("n4_idle_busy", busy1, 0);
    // all four channels requesting: grant order depends on arbitration mode
    req1 = 4'b1111; rw1 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack1(a1);
      chk($sformatf("arb4_%0d", k), a1, exp1[k]);
    end
    req1 = 4'b0000;
    // request withdrawn in LATCH; late address change is ignored
    @(negedge clk);
    req0 = 2'b10; rw0 = 2'b10; adr0[39:20] = 20'hC0DE5; din0 = 16'h4321;
    @(negedge clk);
    chk("wd_addr_dout", dout0, 16'h0DE5);
    @(negedge clk);
    req0 = 2'b00; adr0[39:20] = 20'hFFFFF;
    @(negedge clk);
    chk("wd_adr_hi", adr_hi0, 4'hC); chk("wd_oe", oe0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("wd_ack", ack0, 2'b10); chk("wd_dtr", dtr0, 16'h4321);
    @(negedge clk);
    chk("wd_ack_once", ack0, 0);
    @(negedge clk);
    chk("wd_quiet_ack", ack0, 0); chk("wd_quiet_busy", busy0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter NCH, default 2, number of requesting channels (1..8).
REQ-002 Parameter DW, default 16, data width; multiplexed address/data bus width.
REQ-003 Parameter AW, default 20, address width; SHALL satisfy AW >= DW.
REQ-004 Parameter WAIT_CYC, default 1, extra data-phase cycles (0..15).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  NCH  per-channel request, held until ack.
REQ-008 rw  in  NCH  per-channel direction: 1 = read, 0 = write.
REQ-009 adr  in  NCH*AW  per-channel address; channel i at [i*AW +: AW].
REQ-010 dtw  in  NCH*DW  per-channel write data; channel i at [i*DW +: DW].
REQ-011 ack  out  NCH  one-cycle completion pulse, one-hot or zero.
REQ-012 dtr  out  DW  read data, shared by all channels.
REQ-013 din  in  DW  external bus input.
REQ-014 dout  out  DW  external bus output value.
REQ-015 isout  out  1  high = drive dout onto the pins.
REQ-016 adr_hi  out  AW-DW  upper address bits (non-multiplexed).
REQ-017 ale  out  1  address latch enable; external latch captures on falling edge.
REQ-018 oe / we  out  1 each  active-high read strobe / write strobe.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, ADDR, LATCH, DATA, DONE; IDLE->ADDR when any eligible req is high; ADDR->LATCH->DATA unconditionally; DATA held WAIT_CYC+1 cycles; DATA->DONE; DONE->IDLE.
REQ-021 Grant, rw, adr and dtw of the winning channel SHALL be captured on the IDLE->ADDR edge; later changes are ignored until the next grant.
REQ-022 ADDR: isout=1, dout=adr[DW-1:0], ale=1; LATCH: isout=1, dout held, ale=0.
REQ-023 adr_hi = captured adr[AW-1:DW] from ADDR through DONE; 0 in IDLE.
REQ-024 Read DATA: isout=0, oe=1; dtr loaded from din on the last DATA cycle; DONE: oe=0.
REQ-025 Write DATA: isout=1, dout=captured dtw, we=1; DONE: we=0, isout=1, dout held (hold time).
REQ-026 ack[grant] SHALL be high exactly during DONE; latency from req-sampling edge to ack high = WAIT_CYC+4 cycles.
REQ-027 dtr SHALL keep the last read value until the next read completes; writes leave it unchanged.
REQ-028 The channel acked in DONE SHALL be ineligible in the following IDLE cycle only.
REQ-029 req dropped mid-transaction: transaction completes and ack still pulses.
REQ-030 oe and we SHALL never be high together; ale never high outside ADDR.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, ack=0, oe=0, we=0, ale=0, isout=0, dout=0, adr_hi=0, busy=0, dtr=0, round-robin pointer=0, regardless of phase.
REQ-032 First grant possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro ARB_RR_EN defined: round-robin; search starts at channel after last granted, pointer updated on each grant.
REQ-034 ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Structure
REQ-035 Package bus_pkg SHALL hold FSM state encoding and parameter defaults.
REQ-036 Grant selection SHALL be a sub-module rr_arbiter (req, mask, pointer in; one-hot grant out), both modes.

Verification
REQ-037 Single read ch0, WAIT_CYC=1, adr=20'hA1234, din=16'hBEEF in DATA -> dout=16'h1234 with ale, adr_hi=4'hA, oe 2 cycles, ack[0] at cycle 5, dtr=16'hBEEF.
REQ-038 Write ch1 adr=20'h00010 dtw=16'h5A5A -> we high 2 cycles with dout=16'h5A5A, held in DONE, ack[1] one cycle, dtr unchanged.
REQ-039 ch0 and ch1 requesting continuously, ARB_RR_EN defined -> grants alternate 0,1,0,1; undefined -> ch0 served back-to-back except masked cycle admits ch1.
REQ-040 rst_n pulsed low during DATA of a write -> we, isout, busy fall asynchronously; no ack; next request starts cleanly from ADDR.
REQ-041 NCH=4, DW=8, AW=12, WAIT_CYC=0 read adr=12'h3C7 -> dout=8'hC7, adr_hi=4'h3, ack at cycle 4.
REQ-042 req withdrawn during LATCH -> DATA/DONE proceed, ack still pulses once.
